// File: rtl/noc_local_endpoint_if.sv
// Handshake and flit bus between a processing element / mesh router and its local endpoint.
// The endpoint uses the slave modport; the environment (PE plus router) uses master.
interface noc_local_endpoint_if;
   logic        tx_valid_i;
   logic        tx_ready_o;
   logic [3:0]  tx_dest_i;
   logic [7:0]  tx_payload_i;
   logic [16:0] net_data_o;
   logic        net_full_i;
   logic [16:0] net_data_i;
   logic        rx_valid_o;
   logic [3:0]  rx_src_o;
   logic [7:0]  rx_payload_o;

   modport slave (
      input  tx_valid_i, tx_dest_i, tx_payload_i, net_full_i, net_data_i,
      output tx_ready_o, net_data_o, rx_valid_o, rx_src_o, rx_payload_o
   );

   modport master (
      output tx_valid_i, tx_dest_i, tx_payload_i, net_full_i, net_data_i,
      input  tx_ready_o, net_data_o, rx_valid_o, rx_src_o, rx_payload_o
   );
endinterface

// File: rtl/noc_local_endpoint.sv
// Local-port network interface of one 4x4 mesh router: buffers PE requests into
// 17-bit flits for injection, and checks/delivers flits ejected by the router.
module noc_local_endpoint #(
   parameter int unsigned ROUTER_ID = 0,
   parameter int unsigned TX_DEPTH  = 4,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   noc_local_endpoint_if.slave   ep,
   output logic [CNT_W-1:0]      tx_count_o,
   output logic [CNT_W-1:0]      rx_count_o,
   output logic                  err_misroute_o
);

   localparam int unsigned PTR_W = $clog2(TX_DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam logic [3:0]  MY_ID = 4'(ROUTER_ID);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } tx_state_e;

   logic [11:0]      mem_q [TX_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   tx_state_e        state_q, state_d;
   logic [16:0]      net_data_q, net_data_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic             rx_valid_q, rx_valid_d;
   logic [3:0]       rx_src_q, rx_src_d;
   logic [7:0]       rx_payload_q, rx_payload_d;
   logic             err_q, err_d;

   logic fifo_full;
   logic fifo_empty;
   logic push;
   logic pop;
   logic [11:0] head;

   assign fifo_full  = (occ_q == OCC_W'(TX_DEPTH));
   assign fifo_empty = (occ_q == '0);
   assign push       = ep.tx_valid_i && !fifo_full;
   assign head       = mem_q[rd_ptr_q];

   always_comb begin
      state_d      = state_q;
      net_data_d   = '0;
      tx_cnt_d     = tx_cnt_q;
      rx_cnt_d     = rx_cnt_q;
      rx_valid_d   = 1'b0;
      rx_src_d     = rx_src_q;
      rx_payload_d = rx_payload_q;
      err_d        = err_q;
      pop          = 1'b0;

      // net_full_i only matters here; a flit already in SEND/GAP is never retracted
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty && !ep.net_full_i) begin
               pop        = 1'b1;
               net_data_d = {1'b1, head[11:8], MY_ID, head[7:0]};
               state_d    = SEND;
            end
         end
         SEND: begin
            tx_cnt_d = tx_cnt_q + CNT_W'(1);
            state_d  = GAP;
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      occ_d    = occ_q;
      if (push && !pop) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (pop && !push) begin
         occ_d = occ_q - OCC_W'(1);
      end

      if (ep.net_data_i[16]) begin
         rx_src_d     = ep.net_data_i[11:8];
         rx_payload_d = ep.net_data_i[7:0];
         if (ep.net_data_i[15:12] == MY_ID) begin
            rx_valid_d = 1'b1;
            rx_cnt_d   = rx_cnt_q + CNT_W'(1);
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {ep.tx_dest_i, ep.tx_payload_i};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         occ_q        <= '0;
         state_q      <= IDLE;
         net_data_q   <= '0;
         tx_cnt_q     <= '0;
         rx_cnt_q     <= '0;
         rx_valid_q   <= 1'b0;
         rx_src_q     <= '0;
         rx_payload_q <= '0;
         err_q        <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
         state_q      <= state_d;
         net_data_q   <= net_data_d;
         tx_cnt_q     <= tx_cnt_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_valid_q   <= rx_valid_d;
         rx_src_q     <= rx_src_d;
         rx_payload_q <= rx_payload_d;
         err_q        <= err_d;
      end
   end

   assign ep.tx_ready_o   = !fifo_full;
   assign ep.net_data_o   = net_data_q;
   assign ep.rx_valid_o   = rx_valid_q;
   assign ep.rx_src_o     = rx_src_q;
   assign ep.rx_payload_o = rx_payload_q;
   assign tx_count_o      = tx_cnt_q;
   assign rx_count_o      = rx_cnt_q;
   assign err_misroute_o  = err_q;

endmodule

// File: tb/tb_noc_local_endpoint.sv
// Directed bench: two endpoints (ROUTER_ID 0 with 4-bit counters, ROUTER_ID 9) checked
// against scoreboard queues of expected TX flits and RX deliveries.
`timescale 1ns/1ps
module tb_noc_local_endpoint;

   logic clk;
   logic rst;

   noc_local_endpoint_if a_if ();
   noc_local_endpoint_if b_if ();

   logic [3:0]  a_txc, a_rxc;
   logic        a_err;
   logic [15:0] b_txc, b_rxc;
   logic        b_err;

   noc_local_endpoint #(.ROUTER_ID(0), .TX_DEPTH(4), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst), .ep(a_if),
      .tx_count_o(a_txc), .rx_count_o(a_rxc), .err_misroute_o(a_err)
   );

   noc_local_endpoint #(.ROUTER_ID(9), .TX_DEPTH(4), .CNT_W(16)) dut9 (
      .clk(clk), .rst(rst), .ep(b_if),
      .tx_count_o(b_txc), .rx_count_o(b_rxc), .err_misroute_o(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   int last_cyc   = 0;
   bit have_last  = 1'b0;

   logic [16:0] tx_q [$];
   logic [11:0] rx_q [$];
   logic [3:0]  exp_txc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] flit0(input logic [3:0] d, input logic [7:0] p);
      return {1'b1, d, 4'h0, p};
   endfunction

   task automatic push_req(input logic [3:0] d, input logic [7:0] p);
      a_if.tx_valid_i   = 1'b1;
      a_if.tx_dest_i    = d;
      a_if.tx_payload_i = p;
      tx_q.push_back(flit0(d, p));
   endtask

   always @(posedge clk) cyc++;

   // Scoreboard monitors, sampled on the falling edge
   always @(negedge clk) begin
      if (!rst) begin
         if (a_if.net_data_o[16]) begin
            if (tx_q.size() == 0) begin
               chk("tx_unexpected_flit", 32'(a_if.net_data_o), 32'h0);
            end else begin
               chk("tx_flit_order", 32'(a_if.net_data_o), 32'(tx_q.pop_front()));
            end
            if (have_last) chk("tx_spacing_ge3", 32'(cyc - last_cyc >= 3), 32'h1);
            last_cyc  = cyc;
            have_last = 1'b1;
         end else if (a_if.net_data_o != '0) begin
            chk("tx_idle_zero", 32'(a_if.net_data_o), 32'h0);
         end
         if (b_if.rx_valid_o) begin
            if (rx_q.size() == 0) begin
               chk("rx_unexpected_pulse", 32'(b_if.rx_valid_o), 32'h0);
            end else begin
               chk("rx_delivery", 32'({b_if.rx_src_o, b_if.rx_payload_o}), 32'(rx_q.pop_front()));
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      a_if.tx_valid_i = 1'b0; a_if.tx_dest_i = '0; a_if.tx_payload_i = '0;
      a_if.net_full_i = 1'b0; a_if.net_data_i = '0;
      b_if.tx_valid_i = 1'b0; b_if.tx_dest_i = '0; b_if.tx_payload_i = '0;
      b_if.net_full_i = 1'b0; b_if.net_data_i = '0;

      @(negedge clk);
      chk("rst_net_data", 32'(a_if.net_data_o), 32'h0);
      chk("rst_tx_ready", 32'(a_if.tx_ready_o), 32'h1);
      chk("rst_tx_count", 32'(a_txc), 32'h0);
      chk("rst_rx_valid", 32'(a_if.rx_valid_o), 32'h0);
      chk("rst_err", 32'(a_err), 32'h0);
      chk("rst_b_rx_count", 32'(b_rxc), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Single flit: 2-cycle latency, one cycle wide
      push_req(4'd5, 8'hA7);
      @(negedge clk);
      a_if.tx_valid_i = 1'b0;
      chk("t1_not_early", 32'(a_if.net_data_o), 32'h0);
      @(negedge clk);
      chk("t1_flit", 32'(a_if.net_data_o), 32'h150A7);
      @(negedge clk);
      chk("t1_one_cycle", 32'(a_if.net_data_o), 32'h0);
      chk("t1_tx_count", 32'(a_txc), 32'h1);

      // Fill FIFO under back-pressure, then drain
      a_if.net_full_i = 1'b1;
      push_req(4'd1, 8'h10);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         chk("t2_ready_while_filling", 32'(a_if.tx_ready_o), 32'h1);
         push_req(4'(i + 1), 8'(8'h10 + i));
      end
      @(negedge clk);
      a_if.tx_valid_i = 1'b0;
      chk("t2_ready_low_full", 32'(a_if.tx_ready_o), 32'h0);
      chk("t2_held", 32'(a_if.net_data_o), 32'h0);
      repeat (2) begin
         @(negedge clk);
         chk("t2_held", 32'(a_if.net_data_o), 32'h0);
      end
      a_if.net_full_i = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk("t2_drain_flit", 32'(a_if.net_data_o), 32'(flit0(4'(j + 1), 8'(8'h10 + j))));
         if (j == 0) chk("t2_ready_after_pop", 32'(a_if.tx_ready_o), 32'h1);
         repeat (2) begin
            @(negedge clk);
            chk("t2_gap", 32'(a_if.net_data_o), 32'h0);
         end
      end
      chk("t2_tx_count", 32'(a_txc), 32'h5);

      // net_full_i rises during SEND: current flit completes, next is withheld
      push_req(4'd7, 8'h55);
      @(negedge clk);
      push_req(4'd8, 8'h66);
      @(negedge clk);
      a_if.tx_valid_i = 1'b0;
      a_if.net_full_i = 1'b1;
      chk("t3_flit_a", 32'(a_if.net_data_o), 32'(flit0(4'd7, 8'h55)));
      repeat (6) begin
         @(negedge clk);
         chk("t3_withheld", 32'(a_if.net_data_o), 32'h0);
      end
      a_if.net_full_i = 1'b0;
      @(negedge clk);
      chk("t3_flit_b", 32'(a_if.net_data_o), 32'(flit0(4'd8, 8'h66)));
      @(negedge clk);
      chk("t3_tx_count", 32'(a_txc), 32'h7);

      // Counter wrap with CNT_W=4: ... 15 -> 0 -> 1
      exp_txc = 4'd7;
      for (int k = 0; k < 10; k++) begin
         push_req(4'(k), 8'(8'h80 + k));
         @(negedge clk);
         a_if.tx_valid_i = 1'b0;
         @(negedge clk);
         @(negedge clk);
         exp_txc = exp_txc + 4'd1;
         chk("wrap_tx_count", 32'(a_txc), 32'(exp_txc));
      end
      repeat (3) @(negedge clk);

      // RX path on the ROUTER_ID=9 endpoint
      b_if.net_data_i = 17'h193C4;
      rx_q.push_back({4'd3, 8'hC4});
      @(negedge clk);
      chk("rx_valid", 32'(b_if.rx_valid_o), 32'h1);
      chk("rx_src", 32'(b_if.rx_src_o), 32'h3);
      chk("rx_payload", 32'(b_if.rx_payload_o), 32'hC4);
      chk("rx_count", 32'(b_rxc), 32'h1);
      b_if.net_data_i = 17'h125E1;
      @(negedge clk);
      chk("misroute_no_valid", 32'(b_if.rx_valid_o), 32'h0);
      chk("misroute_err", 32'(b_err), 32'h1);
      chk("misroute_src", 32'(b_if.rx_src_o), 32'h5);
      chk("misroute_payload", 32'(b_if.rx_payload_o), 32'hE1);
      b_if.net_data_i = '0;
      @(negedge clk);
      chk("err_sticky", 32'(b_err), 32'h1);
      chk("rx_idle_no_valid", 32'(b_if.rx_valid_o), 32'h0);
      chk("rx_hold_payload", 32'(b_if.rx_payload_o), 32'hE1);
      chk("rx_count_unchanged", 32'(b_rxc), 32'h1);
      b_if.net_data_i = 17'h19711;
      rx_q.push_back({4'd7, 8'h11});
      @(negedge clk);
      chk("rx_b2b_first", 32'(b_if.rx_valid_o), 32'h1);
      b_if.net_data_i = 17'h19822;
      rx_q.push_back({4'd8, 8'h22});
      @(negedge clk);
      chk("rx_b2b_second", 32'(b_if.rx_valid_o), 32'h1);
      chk("rx_b2b_payload", 32'(b_if.rx_payload_o), 32'h22);
      b_if.net_data_i = 17'h09FFF;
      @(negedge clk);
      chk("rx_invalid_flit_ignored", 32'(b_if.rx_valid_o), 32'h0);
      chk("rx_hold_src", 32'(b_if.rx_src_o), 32'h8);
      chk("rx_count_b2b", 32'(b_rxc), 32'h3);
      b_if.net_data_i = '0;

      // Reset while in SEND with three flits still queued
      a_if.net_full_i = 1'b1;
      push_req(4'd2, 8'hD0);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         push_req(4'd2, 8'(8'hD0 + i));
      end
      @(negedge clk);
      a_if.tx_valid_i = 1'b0;
      a_if.net_full_i = 1'b0;
      @(negedge clk);
      chk("rst_pre_send_flit", 32'(a_if.net_data_o), 32'(flit0(4'd2, 8'hD0)));
      #2 rst = 1'b1;
      #1;
      chk("rst_async_net_zero", 32'(a_if.net_data_o), 32'h0);
      chk("rst_async_ready", 32'(a_if.tx_ready_o), 32'h1);
      chk("rst_async_tx_count", 32'(a_txc), 32'h0);
      chk("rst_async_b_err", 32'(b_err), 32'h0);
      chk("rst_async_b_rx_count", 32'(b_rxc), 32'h0);
      tx_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) begin
         @(negedge clk);
         chk("post_rst_no_stale", 32'(a_if.net_data_o), 32'h0);
         chk("post_rst_ready", 32'(a_if.tx_ready_o), 32'h1);
         chk("post_rst_tx_count", 32'(a_txc), 32'h0);
      end

      chk("tx_scoreboard_drained", 32'(tx_q.size()), 32'h0);
      chk("rx_scoreboard_drained", 32'(rx_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
